// File: rtl/regfile_read_ctrl.sv
// regfile_read_ctrl: access controller for an 8 x 16 register file.
// The register file is built from per-word registers that have a load strobe
// and two tri-state read ports (A and B).
//
// Write path (combinational)
//   wr_req, wr_addr, wr_data : write request, index and data
//   load, wr_din             : one-hot load strobe and data to the register Din inputs
//
// Read path (sequenced)
//   rd_req, rd_addr_a/b, rd_ready : read request handshake
//   out_en_a/b                    : one-hot tri-state enables onto the shared read buses
//   bus_a/b                       : shared read buses, driven by the register file
//   op_a/b, op_valid, op_ready    : captured operand pair, valid/ready downstream
//
// Clocking and reset
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
module regfile_read_ctrl #(
  parameter int unsigned DW   = 16,
  parameter int unsigned NREG = 8,
  parameter int unsigned AW   = 3   // must equal $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rd_req,
  input  logic [AW-1:0]   rd_addr_a,
  input  logic [AW-1:0]   rd_addr_b,
  output logic            rd_ready,
  output logic [NREG-1:0] out_en_a,
  output logic [NREG-1:0] out_en_b,
  input  logic [DW-1:0]   bus_a,
  input  logic [DW-1:0]   bus_b,
  output logic [DW-1:0]   op_a,
  output logic [DW-1:0]   op_b,
  output logic            op_valid,
  input  logic            op_ready,
  input  logic            wr_req,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW-1:0]   wr_data,
  output logic [NREG-1:0] load,
  output logic [DW-1:0]   wr_din
);

  typedef enum logic [1:0] {StIdle, StDrive, StHold} state_e;

  state_e          state_q;
  logic [AW-1:0]   addr_a_q, addr_b_q;
  logic [DW-1:0]   op_a_q, op_b_q;
  logic            op_valid_q;
  logic [NREG-1:0] out_en_a_q, out_en_b_q;
  logic            fwd_a, fwd_b;

  // Write path: pure decode, the register array loads on the next edge.
  always_comb begin
    load = '0;
    if (wr_req) load = NREG'(1) << wr_addr;
  end
  assign wr_din = wr_data;

  always_comb begin
    rd_ready = 1'b0;
    unique case (state_q)
      StIdle:  rd_ready = 1'b1;
      StHold:  rd_ready = op_ready;
      default: rd_ready = 1'b0;
    endcase
  end

  // A write landing on the register being read updates on the capture edge,
  // so the bus still shows the old value: take the write data instead.
  assign fwd_a = wr_req && (wr_addr == addr_a_q);
  assign fwd_b = wr_req && (wr_addr == addr_b_q);

  // Enables are registered and set on entry to StDrive, so they are nonzero
  // for exactly that one cycle and are cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_valid_q <= 1'b0;
      out_en_a_q <= '0;
      out_en_b_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rd_req) begin
            addr_a_q   <= rd_addr_a;
            addr_b_q   <= rd_addr_b;
            out_en_a_q <= NREG'(1) << rd_addr_a;
            out_en_b_q <= NREG'(1) << rd_addr_b;
            state_q    <= StDrive;
          end
        end
        StDrive: begin
          op_a_q     <= fwd_a ? wr_data : bus_a;
          op_b_q     <= fwd_b ? wr_data : bus_b;
          op_valid_q <= 1'b1;
          out_en_a_q <= '0;
          out_en_b_q <= '0;
          state_q    <= StHold;
        end
        StHold: begin
          if (op_ready) begin
            op_valid_q <= 1'b0;
            if (rd_req) begin
              addr_a_q   <= rd_addr_a;
              addr_b_q   <= rd_addr_b;
              out_en_a_q <= NREG'(1) << rd_addr_a;
              out_en_b_q <= NREG'(1) << rd_addr_b;
              state_q    <= StDrive;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: begin
          out_en_a_q <= '0;
          out_en_b_q <= '0;
          op_valid_q <= 1'b0;
          state_q    <= StIdle;
        end
      endcase
    end
  end

  assign out_en_a = out_en_a_q;
  assign out_en_b = out_en_b_q;
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign op_valid = op_valid_q;

endmodule

// File: tb/tb_regfile_read_ctrl.sv
// Bench for regfile_read_ctrl: models the 8 x 16 register array with its
// tri-state read ports, applies directed vectors and checks against
// hand-computed values.
module tb_regfile_read_ctrl;

  localparam int unsigned DW = 16;
  localparam int unsigned NREG = 8;
  localparam int unsigned AW = 3;
  localparam logic [DW-1:0] Float = 16'hF1F1;  // undriven-bus marker

  logic            clk, rst_n;
  logic            rd_req, rd_ready, op_valid, op_ready, wr_req;
  logic [AW-1:0]   rd_addr_a, rd_addr_b, wr_addr;
  logic [NREG-1:0] out_en_a, out_en_b, load;
  logic [DW-1:0]   bus_a, bus_b, op_a, op_b, wr_data, wr_din;
  logic [DW-1:0]   regs [NREG];

  int nvec = 0;
  int nmis = 0;

  regfile_read_ctrl #(.DW(DW), .NREG(NREG), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_ready(rd_ready),
    .out_en_a(out_en_a), .out_en_b(out_en_b), .bus_a(bus_a), .bus_b(bus_b),
    .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .load(load), .wr_din(wr_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register array model: loads from the DUT strobes, drives the shared buses.
  initial for (int i = 0; i < NREG; i++) regs[i] = '0;
  always @(posedge clk) begin
    for (int i = 0; i < NREG; i++) if (load[i]) regs[i] <= wr_din;
  end
  always_comb begin
    bus_a = Float;
    bus_b = Float;
    for (int i = 0; i < NREG; i++) begin
      if (out_en_a[i]) bus_a = regs[i];
      if (out_en_b[i]) bus_b = regs[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Bus exclusivity, every cycle outside reset.
  always @(negedge clk) begin
    if (rst_n) begin
      check("onehot_a", 32'($countones(out_en_a) <= 1), 32'd1);
      check("onehot_b", 32'($countones(out_en_b) <= 1), 32'd1);
      check("onehot_ld", 32'($countones(load) <= 1), 32'd1);
      if (out_en_a != '0) check("bus_a_known", 32'($isunknown(bus_a)), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NREG-1:0] ld);
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    #1;
    check("wr_load", 32'(load), 32'(ld));
    check("wr_din", 32'(wr_din), 32'(d));
    tick();
    wr_req = 1'b0;
  endtask

  // Read from IDLE with op_ready=1: DRIVE enables, then captured pair, then IDLE.
  task automatic read(input logic [AW-1:0] a, input logic [AW-1:0] b,
                      input logic [NREG-1:0] ena, input logic [NREG-1:0] enb,
                      input logic [DW-1:0] xa, input logic [DW-1:0] xb);
    rd_req = 1'b1; rd_addr_a = a; rd_addr_b = b; op_ready = 1'b1;
    #1;
    check("rd_ready_idle", 32'(rd_ready), 32'd1);
    tick();
    rd_req = 1'b0;
    check("drive_en_a", 32'(out_en_a), 32'(ena));
    check("drive_en_b", 32'(out_en_b), 32'(enb));
    check("drive_rdy", 32'(rd_ready), 32'd0);
    check("drive_vld", 32'(op_valid), 32'd0);
    tick();
    check("hold_vld", 32'(op_valid), 32'd1);
    check("hold_op_a", 32'(op_a), 32'(xa));
    check("hold_op_b", 32'(op_b), 32'(xb));
    check("hold_en", 32'({out_en_a, out_en_b}), 32'd0);
    tick();
    check("idle_vld", 32'(op_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; rd_req = 1'b0; rd_addr_a = '0; rd_addr_b = '0; op_ready = 1'b0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    #12;
    check("rst_vld", 32'(op_valid), 32'd0);
    check("rst_op", 32'({op_a, op_b}), 32'd0);
    check("rst_en", 32'({out_en_a, out_en_b}), 32'd0);
    check("rst_load", 32'(load), 32'd0);
    check("rst_rdy", 32'(rd_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic read of R3/R5.
    write(3'd3, 16'h1234, 8'h08);
    write(3'd5, 16'hABCD, 8'h20);
    read(3'd3, 3'd5, 8'h08, 8'h20, 16'h1234, 16'hABCD);

    // Same register on both buses.
    write(3'd7, 16'h00FF, 8'h80);
    read(3'd7, 3'd7, 8'h80, 8'h80, 16'h00FF, 16'h00FF);

    // Forwarding during DRIVE, then snapshot under a write in HOLD.
    write(3'd2, 16'h1111, 8'h04);
    rd_req = 1'b1; rd_addr_a = 3'd2; rd_addr_b = 3'd3; op_ready = 1'b0;
    tick();
    rd_req = 1'b0;
    wr_req = 1'b1; wr_addr = 3'd2; wr_data = 16'h2222;
    tick();
    check("fwd_op_a", 32'(op_a), 32'h2222);
    check("fwd_op_b", 32'(op_b), 32'h1234);
    wr_addr = 3'd3; wr_data = 16'h3333;
    tick();
    wr_req = 1'b0;
    check("snap_op_b", 32'(op_b), 32'h1234);
    check("snap_vld", 32'(op_valid), 32'd1);
    op_ready = 1'b1;
    tick();
    read(3'd2, 3'd3, 8'h04, 8'h08, 16'h2222, 16'h3333);

    // Backpressure, then back-to-back read with no IDLE cycle.
    rd_req = 1'b1; rd_addr_a = 3'd5; rd_addr_b = 3'd7; op_ready = 1'b0;
    tick();
    rd_addr_a = 3'd3; rd_addr_b = 3'd2;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("bp_vld", 32'(op_valid), 32'd1);
      check("bp_ops", {op_a, op_b}, 32'hABCD_00FF);
      check("bp_rdy", 32'(rd_ready), 32'd0);
      check("bp_en", 32'({out_en_a, out_en_b}), 32'd0);
      tick();
    end
    op_ready = 1'b1;
    #1;
    check("b2b_rdy", 32'(rd_ready), 32'd1);
    tick();
    rd_req = 1'b0;
    check("b2b_en", 32'({out_en_a, out_en_b}), 32'h0804);
    check("b2b_vld", 32'(op_valid), 32'd0);
    tick();
    check("b2b_ops", {op_a, op_b}, 32'h3333_2222);
    check("b2b_vld2", 32'(op_valid), 32'd1);
    tick();

    // Simultaneous read and write in IDLE: read sees the new value.
    rd_req = 1'b1; rd_addr_a = 3'd6; rd_addr_b = 3'd5;
    wr_req = 1'b1; wr_addr = 3'd6; wr_data = 16'h6666;
    #1;
    check("rw_load", 32'(load), 32'h40);
    tick();
    rd_req = 1'b0; wr_req = 1'b0;
    check("rw_en_a", 32'(out_en_a), 32'h40);
    tick();
    check("rw_ops", {op_a, op_b}, 32'h6666_ABCD);
    tick();

    // Reset between edges while in DRIVE.
    rd_req = 1'b1; rd_addr_a = 3'd1; rd_addr_b = 3'd4;
    tick();
    rd_req = 1'b0;
    check("mid_en_pre", 32'({out_en_a, out_en_b}), 32'h0210);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_en", 32'({out_en_a, out_en_b}), 32'd0);
    check("mid_vld", 32'(op_valid), 32'd0);
    check("mid_rdy", 32'(rd_ready), 32'd1);
    check("mid_load", 32'(load), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check("post_vld", 32'(op_valid), 32'd0);
    check("post_en", 32'({out_en_a, out_en_b}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
